// File: rtl/rock_core_pkg.sv
// -----------------------------------------------------------------------------
// rock_core_pkg
// Shared definitions for the rock core front end: data widths, the canonical
// NOP, the fetch FSM state encoding and the {pc, instruction} buffer entry.
// -----------------------------------------------------------------------------
package rock_core_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;

  // addi x0, x0, 0 -- presented to decode whenever no real instruction is held.
  localparam logic [ILEN-1:0] NOP_INSTRUCTION = 32'h0000_0013;

  typedef enum logic [1:0] {
    FETCH_IDLE = 2'd0,
    FETCH_RUN  = 2'd1,
    FETCH_HALT = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;

  // Instruction fetches are word-granular; any low address bit set is illegal.
  function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
// Synchronous FIFO of fetched {pc, instruction} entries with flush.
// The head entry is visible combinationally, so a word pushed on one edge can
// be handed to decode in the very next cycle.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   i_push/i_data   write an entry (ignored while flushing)
//   i_pop           remove the head entry (ignored when empty or flushing)
//   i_flush         discard every entry
//   o_data          head entry
//   o_count         number of valid entries
//   o_empty/o_full  occupancy flags
// -----------------------------------------------------------------------------
module fetch_fifo
  import rock_core_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_push,
  input  fetch_entry_t           i_data,
  input  logic                   i_pop,
  input  logic                   i_flush,
  output fetch_entry_t           o_data,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_empty,
  output logic                   o_full
);

  localparam int AW = $clog2(DEPTH);

  fetch_entry_t   r_mem [DEPTH];
  logic [AW-1:0]  r_wr_ptr;
  logic [AW-1:0]  r_rd_ptr;
  logic [AW:0]    r_count;

  logic w_push;
  logic w_pop;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_data  = r_mem[r_rd_ptr];
  assign o_count = r_count;

  assign w_pop  = i_pop && !o_empty && !i_flush;
  // A full buffer may still accept a push in the same cycle its head leaves.
  assign w_push = i_push && !i_flush && (!o_full || w_pop);

  // NOTE: storage has no reset; only the pointers and count define validity,
  // so leaving the array unreset keeps it a plain RAM with no reset fan-out.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // NOTE: all state registers use non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// -----------------------------------------------------------------------------
// instruction_fetch_unit
// Owns the PC, issues in-order instruction-memory reads, buffers returned
// words and hands {instruction, pc} to decode over a valid/ready handshake.
// Execute can redirect the PC; words already in flight at a redirect are
// dropped as they return. A redirect to a non-word-aligned target halts fetch
// until reset and raises the sticky fetch_misaligned flag.
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   imem_req_valid/ready/addr      read request channel (addr = PC)
//   imem_resp_valid/data           in-order read data, >=1 cycle after accept
//   redirect_valid/target          PC change from execute
//   if_valid/ready                 handshake towards decode
//   if_instruction/if_pc           head instruction and its address
//   fetch_misaligned               sticky misaligned-redirect flag
// -----------------------------------------------------------------------------
module instruction_fetch_unit
  import rock_core_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC        = 32'h0000_0000,
  parameter int              FIFO_DEPTH      = 2,
  parameter int              MAX_OUTSTANDING = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [ILEN-1:0] imem_resp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [ILEN-1:0] if_instruction,
  output logic [XLEN-1:0] if_pc,
  output logic            fetch_misaligned
);

  localparam int OW  = $clog2(MAX_OUTSTANDING + 1);
  localparam int CW  = $clog2(FIFO_DEPTH) + 1;
  localparam int AQW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  fetch_state_e    r_state;
  logic [XLEN-1:0] r_pc;
  logic [OW-1:0]   r_outstanding;
  logic [OW-1:0]   r_drop_count;
  logic            r_misaligned;

  // Address of every accepted request, consumed as its response returns.
  logic [XLEN-1:0] r_aq [MAX_OUTSTANDING];
  logic [AQW-1:0]  r_aq_wr;
  logic [AQW-1:0]  r_aq_rd;

  logic            w_run;
  logic            w_redirect;
  logic            w_credit_ok;
  logic            w_accept;
  logic            w_resp_drop;
  logic            w_push;
  logic            w_pop;
  logic            w_flush;
  logic [OW-1:0]   w_out_next;
  fetch_entry_t    w_push_entry;
  fetch_entry_t    w_fifo_head;
  logic [CW-1:0]   w_fifo_count;
  logic            w_fifo_empty;
  logic            w_fifo_full;

  function automatic logic [AQW-1:0] aq_next(input logic [AQW-1:0] ptr);
    return (ptr == AQW'(MAX_OUTSTANDING - 1)) ? '0 : ptr + 1'b1;
  endfunction

  assign w_run      = (r_state == FETCH_RUN);
  assign w_redirect = w_run && redirect_valid;

  // Output side: the handshake is masked while a redirect is being taken.
  assign if_valid       = w_run && !redirect_valid && !w_fifo_empty;
  assign w_pop          = if_valid && if_ready;
  assign if_instruction = w_fifo_empty ? NOP_INSTRUCTION : w_fifo_head.instr;
  assign if_pc          = w_fifo_empty ? '0 : w_fifo_head.pc;

  // Credit: every in-flight word must have a buffer slot waiting for it. The
  // slot freed by a pop this cycle counts, which keeps a depth-2 buffer
  // streaming one instruction per cycle against a single-cycle memory.
  assign w_credit_ok = (int'(r_outstanding) + int'(w_fifo_count) - int'(w_pop)) < FIFO_DEPTH;

  assign imem_req_valid = w_run && !redirect_valid && w_credit_ok &&
                          (int'(r_outstanding) < MAX_OUTSTANDING);
  assign imem_req_addr  = r_pc;
  assign w_accept       = imem_req_valid && imem_req_ready;

  assign w_out_next  = r_outstanding + OW'(w_accept) - OW'(imem_resp_valid);
  assign w_resp_drop = imem_resp_valid && (r_drop_count != '0);
  assign w_push      = imem_resp_valid && !w_resp_drop && w_run && !redirect_valid;
  assign w_flush     = w_redirect || (r_state == FETCH_HALT);

  assign w_push_entry = '{pc: r_aq[r_aq_rd], instr: imem_resp_data};

  assign fetch_misaligned = r_misaligned;

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (w_push_entry),
    .i_pop   (w_pop),
    .i_flush (w_flush),
    .o_data  (w_fifo_head),
    .o_count (w_fifo_count),
    .o_empty (w_fifo_empty),
    .o_full  (w_fifo_full)
  );

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_aq[r_aq_wr] <= r_pc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_aq_wr <= '0;
      r_aq_rd <= '0;
    end else begin
      if (w_accept)        r_aq_wr <= aq_next(r_aq_wr);
      if (imem_resp_valid) r_aq_rd <= aq_next(r_aq_rd);
    end
  end

  // Fetch control: FSM, PC, in-flight and drop counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= FETCH_IDLE;
      r_pc          <= RESET_PC;
      r_outstanding <= '0;
      r_drop_count  <= '0;
      r_misaligned  <= 1'b0;
    end else begin
      r_outstanding <= w_out_next;
      unique case (r_state)
        FETCH_IDLE: r_state <= FETCH_RUN;
        FETCH_RUN: begin
          if (redirect_valid) begin
            // Everything still in flight after this edge belongs to the old path.
            r_drop_count <= w_out_next;
            if (is_misaligned(redirect_target)) begin
              r_misaligned <= 1'b1;
              r_state      <= FETCH_HALT;
            end else begin
              r_pc <= redirect_target;
            end
          end else begin
            if (w_accept)    r_pc         <= r_pc + 32'd4;
            if (w_resp_drop) r_drop_count <= r_drop_count - 1'b1;
          end
        end
        FETCH_HALT: begin
          if (w_resp_drop) r_drop_count <= r_drop_count - 1'b1;
        end
        default: r_state <= FETCH_IDLE;
      endcase
    end
  end

  // A response with nothing in flight breaks the memory protocol.
  a_resp_in_flight: assert property (@(posedge clk) disable iff (rst)
    imem_resp_valid |-> (r_outstanding != '0));

  // The credit check must make a push into a full buffer impossible.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    w_push |-> (!w_fifo_full || w_pop));

endmodule
